program_loader: RTL
===================

# program_loader

Instruction-memory loader that sits upstream of the control unit: it accepts a byte stream on a valid/ready handshake, assembles 17-bit instruction words, and writes them into instruction memory at sequential 8-bit addresses. While loading it holds the control unit's pipeline frozen. It releases the CPU only after a complete, and optionally checksum-verified, program is in memory.

## Interface
- ADDR_W, 8, instruction-memory address width (matches the 8-bit PC)
- INSTR_W, 17, instruction word width
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that begins a load; ignored unless idle
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts in_data this cycle
- imem_we  output  1  instruction-memory write strobe, one cycle
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  INSTR_W  assembled instruction
- cpu_hold  output  1  freeze/hold request to the control unit
- busy  output  1  load in progress
- done  output  1  one-cycle pulse at end of load
- error  output  1  sticky checksum failure

## Operation
- Stream format after start:
  - Byte 0 is N, the word count. N=0 means 256 words.
  - Then 3 bytes per word, MSB first: hi, mid, lo.
  - Word = {hi[0], mid, lo}. hi[7:1] is ignored.
- A byte transfers on a rising edge where in_valid && in_ready.
- States: IDLE → COUNT → B_HI → B_MID → B_LO → WRITE → (B_HI | CHECK | DONE) → IDLE.
  - IDLE: in_ready=0. On start: clear error, addr=0, sum=0, cpu_hold=1, go to COUNT.
  - COUNT: accept N. Load the remaining counter with N (0 → 256).
  - B_HI / B_MID / B_LO: accept one byte each into the shift register.
  - WRITE: in_ready=0. imem_we=1 with addr/wdata stable. Then addr++, remaining--. Go to B_HI if remaining≠0, else CHECK (macro on) or DONE.
  - CHECK: accept one checksum byte, then go to DONE.
  - DONE: done=1 for one cycle. Drop cpu_hold unless error=1. Go to IDLE.
- busy=1 in every state except IDLE.
- Address counter is ADDR_W bits and wraps modulo 256. A 256-word load ends at address 255, and the counter wraps to 0 without an extra write.
- start while busy: ignored.
- start and in_valid in the same IDLE cycle: the byte is not accepted.
- in_valid may drop mid-word. The FSM waits in its state with no timeout.
- Reset mid-load: every register returns to its reset value immediately and the partial word is discarded. Memory contents already written are not restored.

## Timing
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_hold=0, busy=0, done=0, error=0, state=IDLE
- start sampled at edge k: busy=1, cpu_hold=1 and in_ready=1 from cycle k+1.
- Byte lo accepted at edge k: imem_we=1 during cycle k+1, and in_ready=0 during k+1.
- Throughput: 4 cycles per word at full in_valid.
- Minimum load time: 1 (start) + 1 (N) + 4N (+1 checksum) + 1 (DONE) cycles.
- done is high in the cycle after the last accepted byte, or the cycle after the last WRITE when the macro is off.
- cpu_hold falls on the same edge that done falls.
- All outputs are registered; there are no combinational input-to-output paths except in_ready, which is decoded from state.

## Configuration
- PROGRAM_LOADER_CHECKSUM_EN defined:
  - A trailing checksum byte is expected.
  - Checksum = 8-bit modulo-256 sum of N and all 3N data bytes.
  - On mismatch: error=1, done still pulses, cpu_hold stays 1 until the next start.
- Undefined:
  - No CHECK state and no trailing byte.
  - error is tied 0 and the sum logic is removed.

## Structure
- Shared package holds:
  - the state enum (IDLE, COUNT, B_HI, B_MID, B_LO, WRITE, CHECK, DONE)
  - INSTR_W=17 and ADDR_W=8 constants, shared with the control unit
  - BYTES_PER_WORD=3
- One natural sub-module: byte_assembler. It is a 3-byte shift register with a load-complete flag and drives imem_wdata.
- FSM, counters and checksum stay in program_loader.

## Test plan
- N=2, bytes 01 AB CD, 00 12 34, in_valid held high → writes 0x1ABCD@0 then 0x01234@1; done 10 cycles after start; cpu_hold 1→0.
- N=0 with 768 bytes of pattern 00 00 xx (xx = address) → 256 writes, last at addr 255 with wdata 0x000FF; imem_addr wraps to 0; exactly 256 imem_we pulses.
- Checksum on: N=1, bytes FE 00 01, checksum 0x00 (01+FE+00+01 mod 256) → error=0, cpu_hold released. Checksum 0x55 → error=1, done pulses, cpu_hold stays 1.
- in_valid gaps of 3 cycles between every byte, N=1, word 0x1FFFF → single correct write; in_ready never high during WRITE.
- Second start pulse during load, plus start coincident with in_valid=1 in IDLE → second start is ignored; the coincident byte is not consumed (first byte accepted is the one presented in the cycle after start).
- reset low asynchronously after the mid byte of word 1 → all outputs at reset values within the same cycle; a fresh load afterwards writes from addr 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared constants for the instruction-memory loader and the control unit.
// State codes cover the optional checksum build (PROGRAM_LOADER_CHECKSUM_EN).
package program_loader_pkg;

    localparam int ADDR_W         = 8;
    localparam int INSTR_W        = 17;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_B_HI  = 3'd2;
    localparam logic [2:0] ST_B_MID = 3'd3;
    localparam logic [2:0] ST_B_LO  = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;
    localparam logic [2:0] ST_CHECK = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    // A count byte of zero encodes a full 256-word program.
    function automatic logic [ADDR_W:0] word_count(input logic [BYTE_W-1:0] n);
        return (n == '0) ? (ADDR_W+1)'(1 << ADDR_W) : (ADDR_W+1)'(n);
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Collects hi/mid/lo bytes into one instruction word; o_complete pulses
// for one cycle alongside the freshly assembled word.
module program_loader_byte_assembler
    import program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_shift_en,
    input  logic [BYTE_W-1:0]  i_byte,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_complete
);

    logic [1:0]         r_count;
    logic               r_hi_bit;
    logic [BYTE_W-1:0]  r_mid;
    logic [INSTR_W-1:0] r_word;
    logic               r_complete;

    // Only bit 0 of the hi byte survives; it is peeled off as the mid byte arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_hi_bit   <= 1'b0;
            r_mid      <= '0;
            r_word     <= '0;
            r_complete <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_shift_en) begin
                r_hi_bit <= r_mid[0];
                r_mid    <= i_byte;
                if (r_count == 2'(BYTES_PER_WORD - 1)) begin
                    r_count    <= '0;
                    r_word     <= {r_hi_bit, r_mid, i_byte};
                    r_complete <= 1'b1;
                end else begin
                    r_count <= r_count + 2'd1;
                end
            end
        end
    end

    assign o_word     = r_word;
    assign o_complete = r_complete;

endmodule

// File: rtl/program_loader.sv
// Streams a byte-packed program into instruction memory while holding the CPU.
// Define PROGRAM_LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module program_loader
    import program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_in_valid,
    input  logic [BYTE_W-1:0]  i_in_data,
    output logic               o_in_ready,
    output logic               o_imem_we,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [INSTR_W-1:0] o_imem_wdata,
    output logic               o_cpu_hold,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error
);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_busy;
    logic              r_cpu_hold;
    logic              r_done;

    logic w_in_ready;
    logic w_accept;
    logic w_start_load;
    logic w_shift_en;
    logic w_last_word;
    logic w_error;

    assign w_in_ready   = (r_state == ST_COUNT) || (r_state == ST_B_HI) ||
                          (r_state == ST_B_MID) || (r_state == ST_B_LO) ||
                          (r_state == ST_CHECK);
    assign w_accept     = i_in_valid && w_in_ready;
    assign w_start_load = (r_state == ST_IDLE) && i_start;
    assign w_shift_en   = w_accept && ((r_state == ST_B_HI) || (r_state == ST_B_MID) ||
                                       (r_state == ST_B_LO));
    assign w_last_word  = (r_remaining == (ADDR_W+1)'(1));

    program_loader_byte_assembler u_byte_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_start_load),
        .i_shift_en (w_shift_en),
        .i_byte     (i_in_data),
        .o_word     (o_imem_wdata),
        .o_complete (o_imem_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_COUNT;
                        r_addr     <= '0;
                        r_busy     <= 1'b1;
                        r_cpu_hold <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (w_accept) begin
                        r_remaining <= word_count(i_in_data);
                        r_state     <= ST_B_HI;
                    end
                end
                ST_B_HI: begin
                    if (w_accept) r_state <= ST_B_MID;
                end
                ST_B_MID: begin
                    if (w_accept) r_state <= ST_B_LO;
                end
                ST_B_LO: begin
                    if (w_accept) r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // The address wraps naturally after the 256th word; no extra write follows.
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    if (w_last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_state <= ST_CHECK;
`else
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state <= ST_B_HI;
                    end
                end
                ST_CHECK: begin
                    if (w_accept) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= w_error;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_sum;
    logic              r_error;

    // Running sum covers the count byte and every data byte; the check byte itself is compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_error <= 1'b0;
        end else if (w_start_load) begin
            r_sum   <= '0;
            r_error <= 1'b0;
        end else if (w_accept) begin
            if (r_state == ST_CHECK) begin
                r_error <= (i_in_data != r_sum);
            end else begin
                r_sum <= r_sum + i_in_data;
            end
        end
    end

    assign w_error = r_error;
`else
    assign w_error = 1'b0;
`endif

    assign o_in_ready  = w_in_ready;
    assign o_imem_addr = r_addr;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = w_error;

endmodule
